// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode bit positions, synchroniser edge types and the
// mapping from a raw spi_clk edge to its sample/shift role.
package spi_pkg;

   localparam logic [1:0] MODE_0 = 2'b00;
   localparam logic [1:0] MODE_1 = 2'b01;
   localparam logic [1:0] MODE_2 = 2'b10;
   localparam logic [1:0] MODE_3 = 2'b11;

   localparam int unsigned CPOL_BIT = 1;
   localparam int unsigned CPHA_BIT = 0;

   typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_e;
   typedef enum logic [1:0] {ROLE_IDLE, ROLE_SAMPLE, ROLE_SHIFT} spi_role_e;

   // Leading edge leaves the CPOL level; CPHA picks which edge samples.
   function automatic spi_role_e spi_role(input logic cpol, input logic cpha, input edge_e e);
      logic leading;
      logic trailing;
      leading  = (e == EDGE_RISE && !cpol) || (e == EDGE_FALL && cpol);
      trailing = (e == EDGE_FALL && !cpol) || (e == EDGE_RISE && cpol);
      if (leading) begin
         if (cpha) return ROLE_SHIFT;
         return ROLE_SAMPLE;
      end
      if (trailing) begin
         if (cpha) return ROLE_SAMPLE;
         return ROLE_SHIFT;
      end
      return ROLE_IDLE;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input with a rise/fall detector
// on the synchronised level.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  d,
   output logic  q,
   output edge_e edge_c
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
         prev_r <= RESET_VAL;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign q = sync_r[SYNC_STAGES-1];

   always_comb begin
      edge_c = EDGE_NONE;
      if (q && !prev_r)      edge_c = EDGE_RISE;
      else if (!q && prev_r) edge_c = EDGE_FALL;
   end

endmodule

// File: rtl/spi_slave_multimode.sv
// SPI slave supporting all four CPOL/CPHA modes, oversampled in the clk domain,
// with word-framed receive and a one-deep transmit holding register.
module spi_slave_multimode
   import spi_pkg::*;
#(
   parameter int unsigned       DATA_W      = 8,
   parameter bit                MSB_FIRST   = 1'b1,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] FILL_WORD   = '1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              spi_cs,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_underrun,
   output logic              frame_abort,
   output logic              busy
);

   localparam int unsigned       CNT_W       = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST        = CNT_W'(DATA_W - 1);
   localparam logic [1:0]        SETTLE_DONE = 2'(SYNC_STAGES);

   logic  cs_q, sclk_level_unused, mosi_q;
   edge_e cs_edge_c, sclk_edge_c, mosi_edge_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .d(spi_cs), .q(cs_q), .edge_c(cs_edge_c));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .d(spi_clk), .q(sclk_level_unused), .edge_c(sclk_edge_c));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_q), .edge_c(mosi_edge_unused));

   logic [1:0]        mode_r, mode_n;
   logic [DATA_W-1:0] rx_shift_r, rx_shift_n, tx_shift_r, tx_shift_n, hold_r, hold_n;
   logic [CNT_W-1:0]  rx_cnt_r, rx_cnt_n, tx_cnt_r, tx_cnt_n, tx_idx_c;
   logic              skip_lead_r, skip_lead_n, load_pend_r, load_pend_n;
   logic              armed_r, armed_n;
   logic [1:0]        settle_r, settle_n;
   logic [DATA_W-1:0] rx_data_n, rx_word_c;
   logic              rx_valid_n, tx_ready_n, tx_underrun_n, frame_abort_n, busy_n, miso_n;
   logic              load_c;
   spi_role_e         role_c;

   // Next-state for framing, shift registers, holding register and pulses.
   always_comb begin
      mode_n        = mode_r;
      rx_shift_n    = rx_shift_r;
      rx_cnt_n      = rx_cnt_r;
      tx_shift_n    = tx_shift_r;
      tx_cnt_n      = tx_cnt_r;
      skip_lead_n   = skip_lead_r;
      load_pend_n   = 1'b0;
      hold_n        = hold_r;
      tx_ready_n    = tx_ready;
      busy_n        = busy;
      rx_data_n     = rx_data;
      rx_valid_n    = 1'b0;
      tx_underrun_n = 1'b0;
      frame_abort_n = 1'b0;
      load_c        = load_pend_r;
      rx_word_c     = MSB_FIRST ? {rx_shift_r[DATA_W-2:0], mosi_q}
                                : {mosi_q, rx_shift_r[DATA_W-1:1]};
      role_c        = spi_role(mode_r[CPOL_BIT], mode_r[CPHA_BIT], sclk_edge_c);
      settle_n      = (settle_r == SETTLE_DONE) ? settle_r : settle_r + 2'd1;
      // A CS held low through reset must not start a frame until seen high.
      armed_n       = armed_r | ((settle_r == SETTLE_DONE) && cs_q);

      if (armed_r && !busy && cs_edge_c == EDGE_FALL) begin
         mode_n      = mode;
         rx_cnt_n    = '0;
         tx_cnt_n    = '0;
         skip_lead_n = 1'b1;
         busy_n      = 1'b1;
         load_c      = 1'b1;
      end else if (busy && cs_edge_c == EDGE_RISE) begin
         busy_n        = 1'b0;
         frame_abort_n = (rx_cnt_r != '0);
      end else if (busy) begin
         if (role_c == ROLE_SAMPLE) begin
            rx_shift_n = rx_word_c;
            if (rx_cnt_r == LAST) begin
               rx_cnt_n    = '0;
               rx_data_n   = rx_word_c;
               rx_valid_n  = 1'b1;
               load_pend_n = 1'b1;
            end else begin
               rx_cnt_n = rx_cnt_r + CNT_W'(1);
            end
         end else if (role_c == ROLE_SHIFT) begin
            if (mode_r[CPHA_BIT] && skip_lead_r) skip_lead_n = 1'b0;
            else tx_cnt_n = (tx_cnt_r == LAST) ? '0 : tx_cnt_r + CNT_W'(1);
         end
      end

      // Load consumes the old holding word before a same-cycle handshake refills it.
      if (load_c) begin
         if (!tx_ready) begin
            tx_shift_n = hold_r;
            tx_ready_n = 1'b1;
         end else begin
            tx_shift_n    = FILL_WORD;
            tx_underrun_n = 1'b1;
         end
      end
      if (tx_valid && tx_ready) begin
         hold_n     = tx_data;
         tx_ready_n = 1'b0;
      end

      tx_idx_c = MSB_FIRST ? (LAST - tx_cnt_n) : tx_cnt_n;
      miso_n   = busy_n & tx_shift_n[tx_idx_c];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r      <= MODE_0;
         rx_shift_r  <= '0;
         rx_cnt_r    <= '0;
         tx_shift_r  <= '0;
         tx_cnt_r    <= '0;
         skip_lead_r <= 1'b0;
         load_pend_r <= 1'b0;
         hold_r      <= '0;
         armed_r     <= 1'b0;
         settle_r    <= 2'd0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_ready    <= 1'b1;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
         busy        <= 1'b0;
         spi_miso_oe <= 1'b0;
         spi_miso    <= 1'b0;
      end else begin
         mode_r      <= mode_n;
         rx_shift_r  <= rx_shift_n;
         rx_cnt_r    <= rx_cnt_n;
         tx_shift_r  <= tx_shift_n;
         tx_cnt_r    <= tx_cnt_n;
         skip_lead_r <= skip_lead_n;
         load_pend_r <= load_pend_n;
         hold_r      <= hold_n;
         armed_r     <= armed_n;
         settle_r    <= settle_n;
         rx_data     <= rx_data_n;
         rx_valid    <= rx_valid_n;
         tx_ready    <= tx_ready_n;
         tx_underrun <= tx_underrun_n;
         frame_abort <= frame_abort_n;
         busy        <= busy_n;
         spi_miso_oe <= busy_n;
         spi_miso    <= miso_n;
      end
   end

endmodule

// File: tb/tb_spi_slave_multimode.sv
// Bench for spi_slave_multimode: a bit-level SPI master plus a word-level model
// of what each frame must deliver (rx words, tx words, underruns, aborts).
module tb_spi_slave_multimode;

   localparam int H = 80;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mode;
   logic        cs8, cs16, spi_clk, spi_mosi;

   logic        miso8, oe8, rxv8, tx_valid8, tx_ready8, under8, abort8, busy8;
   logic [7:0]  rx_data8, tx_data8;
   logic        miso16, oe16, rxv16, tx_valid16, tx_ready16, under16, abort16, busy16;
   logic [15:0] rx_data16, tx_data16;

   always #5 clk = ~clk;

   spi_slave_multimode u_dut8 (
      .clk(clk), .reset(reset), .mode(mode), .spi_cs(cs8), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(miso8), .spi_miso_oe(oe8), .rx_data(rx_data8),
      .rx_valid(rxv8), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
      .tx_underrun(under8), .frame_abort(abort8), .busy(busy8));

   spi_slave_multimode #(.DATA_W(16), .MSB_FIRST(1'b0)) u_dut16 (
      .clk(clk), .reset(reset), .mode(mode), .spi_cs(cs16), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(miso16), .spi_miso_oe(oe16), .rx_data(rx_data16),
      .rx_valid(rxv16), .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
      .tx_underrun(under16), .frame_abort(abort16), .busy(busy16));

   int n_chk = 0, n_fail = 0;
   int underrun_seen = 0, abort_seen = 0, rxv8_cnt = 0, rxv16_cnt = 0;
   logic [7:0]  push_q[$], avail[$], exp_rx[$];
   logic [31:0] mosi_words[$], miso_words[$];
   logic [7:0]  last_rx = 8'h00;
   int m_sel = 0, m_w = 8;
   bit m_msb = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle checks of both instances against the word-level expectations.
   always @(negedge clk) begin
      if (!reset) begin
         chk("oe_busy8", oe8, busy8);
         chk("oe_busy16", oe16, busy16);
         if (!oe8) chk("miso_idle8", miso8, 0);
         if (!oe16) chk("miso_idle16", miso16, 0);
         if (under8) underrun_seen++;
         if (abort8) abort_seen++;
         if (rxv16) rxv16_cnt++;
         if (rxv8) begin
            rxv8_cnt++;
            if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
            else chk("rx_data8", rx_data8, exp_rx.pop_front());
         end
      end
   end

   // Feeds queued words into the 8-bit holding register whenever it is empty.
   initial begin
      tx_valid8 = 1'b0;
      tx_data8  = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset && !tx_valid8 && tx_ready8 && push_q.size() > 0) begin
            tx_data8  = push_q.pop_front();
            tx_valid8 = 1'b1;
         end else begin
            tx_valid8 = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic enqueue(input logic [7:0] w);
      push_q.push_back(w);
      avail.push_back(w);
   endtask

   // Bit-level SPI master; returns early (CS still low) if rst_bit is reached.
   task automatic run_frame(input logic [1:0] md, input int nbits, input int rst_bit);
      logic [31:0] rd;
      logic cpol, cpha;
      int word, pos, idx;
      rd = 0;
      cpol = md[1];
      cpha = md[0];
      miso_words.delete();
      mode = md;
      spi_clk = cpol;
      repeat ($urandom_range(0, 2)) begin
         #40 spi_clk = ~spi_clk;
         #40 spi_clk = ~spi_clk;
      end
      #100;
      if (m_sel == 1) cs16 = 1'b0; else cs8 = 1'b0;
      #150;
      mode = 2'($urandom);
      for (int b = 0; b < nbits; b++) begin
         word = b / m_w;
         pos  = b % m_w;
         idx  = m_msb ? (m_w - 1 - pos) : pos;
         if (b == rst_bit) begin
            reset = 1'b1;
            #1;
            chk("rst_rx_data", rx_data8, 0);
            chk("rst_rx_valid", rxv8, 0);
            chk("rst_busy", busy8, 0);
            chk("rst_oe", oe8, 0);
            chk("rst_miso", miso8, 0);
            chk("rst_tx_ready", tx_ready8, 1);
            #29;
            reset = 1'b0;
            return;
         end
         if (!cpha) begin
            spi_mosi = mosi_words[word][idx];
            #H spi_clk = ~cpol;
            rd[idx] = (m_sel == 1) ? miso16 : miso8;
            #H spi_clk = cpol;
         end else begin
            spi_clk  = ~cpol;
            spi_mosi = mosi_words[word][idx];
            #H spi_clk = cpol;
            rd[idx] = (m_sel == 1) ? miso16 : miso8;
            #H;
         end
         if (pos == m_w - 1) begin
            miso_words.push_back(rd);
            rd = 0;
         end
      end
      #H;
      if (m_sel == 1) cs16 = 1'b1; else cs8 = 1'b1;
      #200;
   endtask

   // Model: one load at frame start and one after every completed word; each
   // takes the oldest supplied word, else FILL_WORD with an underrun.
   task automatic check_frame8(input logic [1:0] md, input int nwords, input int extra);
      logic [7:0] expw[$];
      int exp_under, u0, a0, v0;
      exp_under = 0;
      for (int i = 0; i <= nwords; i++) begin
         if (avail.size() > 0) expw.push_back(avail.pop_front());
         else begin
            expw.push_back(8'hFF);
            exp_under++;
         end
      end
      for (int i = 0; i < nwords; i++) exp_rx.push_back(mosi_words[i][7:0]);
      u0 = underrun_seen;
      a0 = abort_seen;
      v0 = rxv8_cnt;
      m_sel = 0; m_w = 8; m_msb = 1'b1;
      run_frame(md, nwords * 8 + extra, -1);
      repeat (5) @(negedge clk);
      chk("rd_count", miso_words.size(), nwords);
      for (int i = 0; i < nwords && i < miso_words.size(); i++)
         chk("miso_word", miso_words[i], {24'h0, expw[i]});
      chk("underruns", underrun_seen - u0, exp_under);
      chk("aborts", abort_seen - a0, (extra != 0) ? 1 : 0);
      chk("rx_valids", rxv8_cnt - v0, nwords);
      chk("rx_pending", exp_rx.size(), 0);
      if (nwords > 0) last_rx = mosi_words[nwords-1][7:0];
      chk("rx_data_hold", rx_data8, last_rx);
   endtask

   initial begin
      int u0, a0, nw, ex, k;
      logic [1:0] md;
      reset = 1'b1; cs8 = 1'b1; cs16 = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; mode = 2'b00;
      tx_valid16 = 1'b0; tx_data16 = 16'h0;
      repeat (3) @(negedge clk);
      chk("reset_rx_data", rx_data8, 0);
      chk("reset_rx_valid", rxv8, 0);
      chk("reset_tx_ready", tx_ready8, 1);
      chk("reset_underrun", under8, 0);
      chk("reset_abort", abort8, 0);
      chk("reset_busy", busy8, 0);
      chk("reset_oe", oe8, 0);
      chk("reset_miso", miso8, 0);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      // Mode 0: A5 out, 3C in.
      enqueue(8'hA5);
      repeat (4) @(negedge clk);
      mosi_words = {32'h3C};
      check_frame8(2'b00, 1, 0);
      if (miso_words.size() > 0) chk("mode0_miso_a5", miso_words[0], 32'hA5);
      chk("mode0_rx_3c", rx_data8, 8'h3C);

      // Mode 3 back-to-back words.
      enqueue(8'h56);
      enqueue(8'h78);
      repeat (4) @(negedge clk);
      mosi_words = {32'h12, 32'h34};
      check_frame8(2'b11, 2, 0);
      if (miso_words.size() > 1) begin
         chk("mode3_miso_56", miso_words[0], 32'h56);
         chk("mode3_miso_78", miso_words[1], 32'h78);
      end
      chk("mode3_rx_34", rx_data8, 8'h34);

      // Mode 1 with nothing supplied: fill word and two underruns.
      u0 = underrun_seen;
      mosi_words = {32'h9A};
      check_frame8(2'b01, 1, 0);
      if (miso_words.size() > 0) chk("mode1_miso_ff", miso_words[0], 32'hFF);
      chk("mode1_underrun_2", underrun_seen - u0, 2);

      // CS raised after 5 bits.
      mosi_words = {32'h4B};
      check_frame8(2'b00, 0, 5);
      chk("abort_rx_kept_9a", rx_data8, 8'h9A);

      // Reset asserted at bit 3, CS held low across release.
      a0 = abort_seen;
      enqueue(8'h33);
      repeat (4) @(negedge clk);
      m_sel = 0; m_w = 8; m_msb = 1'b1;
      mosi_words = {32'hC3};
      run_frame(2'b00, 8, 3);
      push_q.delete();
      avail.delete();
      exp_rx.delete();
      last_rx = 8'h00;
      repeat (10) @(negedge clk);
      chk("rst_no_restart", busy8, 0);
      chk("rst_no_abort", abort_seen - a0, 0);
      cs8 = 1'b1;
      repeat (10) @(negedge clk);
      enqueue(8'h5A);
      repeat (4) @(negedge clk);
      mosi_words = {32'h96};
      check_frame8(2'b00, 1, 0);
      if (miso_words.size() > 0) chk("post_rst_miso_5a", miso_words[0], 32'h5A);

      // 16-bit LSB-first instance, mode 2.
      @(negedge clk);
      tx_data16 = 16'h8001;
      tx_valid16 = 1'b1;
      @(negedge clk);
      tx_valid16 = 1'b0;
      repeat (3) @(negedge clk);
      k = rxv16_cnt;
      m_sel = 1; m_w = 16; m_msb = 1'b0;
      mosi_words = {32'h00F0};
      run_frame(2'b10, 16, -1);
      repeat (5) @(negedge clk);
      if (miso_words.size() > 0) chk("w16_miso_8001", miso_words[0], 32'h8001);
      else chk("w16_miso_count", 0, 1);
      chk("w16_rx_00f0", rx_data16, 16'h00F0);
      chk("w16_rx_valids", rxv16_cnt - k, 1);

      // Randomised frames against the model.
      for (int f = 0; f < 16; f++) begin
         md = 2'($urandom_range(0, 3));
         nw = $urandom_range(1, 3);
         ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         mosi_words.delete();
         for (int i = 0; i <= nw; i++) mosi_words.push_back(32'($urandom_range(0, 255)));
         k = $urandom_range(0, 4);
         for (int i = 0; i < k; i++) enqueue(8'($urandom_range(0, 255)));
         repeat (4) @(negedge clk);
         check_frame8(md, nw, ex);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
